// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO family: default geometry and
// the read-mode encodings selected through the FWFT parameter.
package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 8;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous read
// port. The array is intentionally not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH      = FIFO_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count,
// overflow/underflow pulses and selectable standard or fall-through read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH         = FIFO_DEFAULT_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = FIFO_STD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_next;
  logic                  empty_r;
  logic                  full_r;
  logic                  aempty_r;
  logic                  afull_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
  assign rd_accept = rd_en && !empty_r;
  assign wr_accept = wr_en && (!full_r || rd_accept);

  // Next occupancy
  always_comb begin
    count_next = count_r;
    if (wr_accept && !rd_accept) begin
      count_next = count_r + CW'(1'b1);
    end else if (rd_accept && !wr_accept) begin
      count_next = count_r - CW'(1'b1);
    end else begin
      count_next = count_r;
    end
  end

  // Pointers, count, flags and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      aempty_r    <= 1'b1;
      afull_r     <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (rd_accept) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r     <= count_next;
      // Flags track the new count so they equal a decode of count_r.
      empty_r     <= (count_next == {CW{1'b0}});
      full_r      <= (count_next == CW'(DEPTH));
      aempty_r    <= (count_next <= CW'(AEMPTY_THRESH));
      afull_r     <= (count_next >= CW'(AFULL_THRESH));
      overflow_r  <= wr_en && !wr_accept;
      underflow_r <= rd_en && empty_r;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_r),
    .wdata (data_in),
    .raddr (rd_ptr_r),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Mask the unreset array so data_out reads zero while empty or in reset.
      assign data_out = empty_r ? {DATA_WIDTH{1'b0}} : mem_rdata;
      assign rd_valid = !empty_r;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_r;
      logic                  valid_r;

      // Registered read data, held between reads
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r  <= {DATA_WIDTH{1'b0}};
          valid_r <= 1'b0;
        end else begin
          valid_r <= rd_accept;
          if (rd_accept) begin
            dout_r <= mem_rdata;
          end
        end
      end

      assign data_out = dout_r;
      assign rd_valid = valid_r;
    end
  endgenerate

  assign count        = count_r;
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = aempty_r;
  assign almost_full  = afull_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
